uart_rx: RTL and testbench

//  Receive side of the UART link; companion to uart_tx, same frame: 1 start, 8 data LSB-first, 1 stop, no parity.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_IDX_W     = $clog2(UART_DATA_BITS);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, mid-bit sampling off a bit timer, byte handed out via valid/ready.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BODE_RATE = 115_200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_data_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BODE_RATE;
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned TIMER_W      = $clog2(CLKS_PER_BIT);

  localparam logic [TIMER_W-1:0]    HALF_LAST = TIMER_W'(HALF - 1);
  localparam logic [TIMER_W-1:0]    BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [UART_IDX_W-1:0] IDX_LAST  = UART_IDX_W'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_rate_check
    $error("uart_rx: CLK_FREQ/BODE_RATE must be at least 4");
  end

  logic                      rx_s;
  logic                      rx_prev;
  uart_rx_state_t            state;
  logic [TIMER_W-1:0]        timer;
  logic [UART_IDX_W-1:0]     bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      accept_c;

  assign accept_c = rx_data_valid && rx_ready;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Receive FSM, bit timer and output holding register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      rx_prev       <= 1'b1;
      timer         <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_prev   <= rx_s;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (accept_c) begin
        rx_data_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= START;
            timer <= '0;
          end
        end

        START: begin
          if (timer == HALF_LAST) begin
            timer <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DATA: begin
          if (timer == BIT_LAST) begin
            timer          <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            if (rx_s) begin
              state <= IDLE;
              // An unaccepted byte wins; an accept in this same cycle frees the slot.
              if (rx_data_valid && !rx_ready) begin
                overrun <= 1'b1;
              end else begin
                rx_data       <= shift;
                rx_data_valid <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit (100 MHz clock, 10 Mbit/s line).
module tb_uart_rx;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       frame_err;
  logic       overrun;

  int checks    = 0;
  int errors    = 0;
  int fe_cycles = 0;
  int ov_cycles = 0;

  uart_rx #(
    .CLK_FREQ  (100_000_000),
    .BODE_RATE (10_000_000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_ready      (rx_ready),
    .frame_err     (frame_err),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Pulse-width accounting for the two single-cycle status outputs.
  always @(negedge clk) begin
    if (frame_err) fe_cycles++;
    if (overrun)   ov_cycles++;
  end

  // One 8N1 frame, 10 clocks per bit; called and returns on a falling clock edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (10) @(negedge clk);
    end
    rx = stop_bit;
    repeat (10) @(negedge clk);
  endtask

  task automatic accept_byte();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    checks++;
    if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_data_valid); end
    checks++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got fe=%b ov=%b expected 0 0", frame_err, overrun);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic_hold();
    int fe0;
    int bad;
    fe0 = fe_cycles;
    bad = 0;
    send_frame(8'hA5, 1'b1);
    checks++;
    if (rx_data_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", rx_data_valid); end
    checks++;
    if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", rx_data); end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rx_data !== 8'hA5 || rx_data_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL basic_hold: got %0d unstable cycles expected 0", bad); end
    accept_byte();
    checks++;
    if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL basic_accept: got valid=%b expected 0", rx_data_valid); end
    checks++;
    if (fe_cycles - fe0 !== 0) begin errors++; $display("FAIL basic_no_fe: got %0d fe cycles expected 0", fe_cycles - fe0); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", rx_data_valid); end
    send_frame(8'hDD, 1'b1);
    checks++;
    if (rx_data_valid !== 1'b1 || rx_data !== 8'hDD) begin
      errors++; $display("FAIL glitch_frame: got valid=%b data=%h expected 1 dd", rx_data_valid, rx_data);
    end
    accept_byte();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_frame_error();
    int fe0;
    int ov0;
    fe0 = fe_cycles;
    ov0 = ov_cycles;
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (fe_cycles - fe0 !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d fe cycles expected 1", fe_cycles - fe0); end
    checks++;
    if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b expected 0", rx_data_valid); end
    checks++;
    if (ov_cycles - ov0 !== 0) begin errors++; $display("FAIL ferr_no_ov: got %0d ov cycles expected 0", ov_cycles - ov0); end
    send_frame(8'h5A, 1'b1);
    checks++;
    if (rx_data_valid !== 1'b1 || rx_data !== 8'h5A) begin
      errors++; $display("FAIL ferr_recover: got valid=%b data=%h expected 1 5a", rx_data_valid, rx_data);
    end
    accept_byte();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int ov0;
    ov0 = ov_cycles;
    send_frame(8'hA5, 1'b1);
    send_frame(8'hDD, 1'b1);
    checks++;
    if (ov_cycles - ov0 !== 1) begin errors++; $display("FAIL b2b_overrun: got %0d ov cycles expected 1", ov_cycles - ov0); end
    checks++;
    if (rx_data_valid !== 1'b1 || rx_data !== 8'hA5) begin
      errors++; $display("FAIL b2b_keep_old: got valid=%b data=%h expected 1 a5", rx_data_valid, rx_data);
    end
    accept_byte();
    checks++;
    if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got valid=%b expected 0", rx_data_valid); end
    repeat (10) @(negedge clk);

    // Second pass: accept lands on exactly the commit edge of the second byte.
    ov0 = ov_cycles;
    send_frame(8'hA5, 1'b1);
    fork
      send_frame(8'hDD, 1'b1);
      begin
        repeat (97) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    checks++;
    if (rx_data_valid !== 1'b1 || rx_data !== 8'hDD) begin
      errors++; $display("FAIL b2b_same_cycle: got valid=%b data=%h expected 1 dd", rx_data_valid, rx_data);
    end
    checks++;
    if (ov_cycles - ov0 !== 0) begin errors++; $display("FAIL b2b_no_ov: got %0d ov cycles expected 0", ov_cycles - ov0); end
    accept_byte();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int fe0;
    int ov0;
    int vcnt;
    fe0  = fe_cycles;
    ov0  = ov_cycles;
    vcnt = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (45) @(negedge clk);
        rst = 1'b0;
      end
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (rx_data_valid) vcnt++;
        end
      end
    join
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (vcnt !== 0 || rx_data_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_valid: got %0d valid cycles, valid=%b expected 0 0", vcnt, rx_data_valid);
    end
    checks++;
    if (fe_cycles - fe0 !== 0 || ov_cycles - ov0 !== 0) begin
      errors++; $display("FAIL midrst_pulses: got fe=%0d ov=%0d expected 0 0", fe_cycles - fe0, ov_cycles - ov0);
    end
    send_frame(8'h96, 1'b1);
    checks++;
    if (rx_data_valid !== 1'b1 || rx_data !== 8'h96) begin
      errors++; $display("FAIL midrst_recover: got valid=%b data=%h expected 1 96", rx_data_valid, rx_data);
    end
    accept_byte();
    repeat (5) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_hold();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
